csr_gpio_in: RTL and testbench
==============================

# csr_gpio_in

Input half of the GPIO block. It captures external pins through a two-flop synchroniser and a per-pin debounce filter, then exposes the filtered levels as a read-only CSR. Programmed rising and falling edges latch into a sticky pending CSR, which drives a level interrupt toward the interrupt controller. It sits beside the GPIO output/direction CSRs on the same CSR bus and uses the same CSR operation encoding.

## Interface
Parameters:
- `PinNum`, default `GpioNum`: number of input pins, 1..32.
- `DataAddr`, default `GpioCsrInData`: CSR address of the filtered level register.
- `PendAddr`, default `GpioCsrInPend`: CSR address of the pending register.
- `Debounce`, default 4: stable cycles required before a level is accepted. 0 bypasses the filter.

Ports:
- `clk`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `csr_enable`, in, 1: CSR instruction valid this cycle.
- `csr_addr`, in, `CsrAddrT`: CSR address.
- `rs1_zimm`, in, `r`: immediate operand for the `*I` ops.
- `rs1_data`, in, `word`: register operand.
- `csr_op`, in, `csr_op_t`: CSR operation.
- `pins`, in, `PinNum`: asynchronous external inputs.
- `rise_mask`, in, `PinNum`: enables rising-edge events per pin.
- `fall_mask`, in, `PinNum`: enables falling-edge events per pin.
- `out`, out, `word`: read data for the addressed CSR, zero-extended. It is 0 when the CSR is not addressed.
- `level`, out, `PinNum`: filtered pin levels.
- `irq`, out, 1: OR of all pending bits.

## Operation
- Synchroniser: `sync1 <= pins`, then `sync2 <= sync1`.
- Debounce uses a per-pin counter `cnt`, `$clog2(Debounce+1)` bits wide. On each edge:
  - if `sync2[k]==level[k]`, then `cnt[k]<=0`;
  - else if `Debounce<=1` or `cnt[k]==Debounce-1`, then `level[k]<=sync2[k]` and `cnt[k]<=0`;
  - else `cnt[k]++`.
- `cnt` never exceeds `Debounce-1`.
- Edge events: when `level[k]` changes 0→1 and `rise_mask[k]` is set, set `pend[k]` on the same edge. A 1→0 change with `fall_mask[k]` set does the same.
- Reads return the pre-operation value, as for all CSRs:
  - `DataAddr` returns `level`;
  - `PendAddr` returns `pend`;
  - any other address returns 0.
- `DataAddr` is read-only. All write effects are ignored.
- Writes to `PendAddr`:
  - CSRRC/CSRRCI clear the bits set in the operand (`rs1_data` or zero-extended `rs1_zimm`).
  - CSRRW/CSRRWI/CSRRS/CSRRSI do not modify `pend`.
  - Operand bits at `PinNum` and above are ignored.
- Set and clear of the same bit on the same edge: set wins, so no event is lost.
- A mask change affects only future level changes. Existing pending bits are kept.
- `irq = |pend`, driven combinationally from the register.

## Timing
- Reset values: `sync1`, `sync2`, `level`, `cnt` and `pend` are all 0. Therefore `out=0` and `irq=0`. Pins that are high at reset produce a rising event once the filter passes.
- Latency: a pin changed before edge N and then held stable updates `level` and `pend` at edge N+1+max(Debounce,1). `irq` is high in the following cycle.
- Glitch rejection: a `sync2` pulse shorter than `Debounce` cycles (for `Debounce>=2`) never reaches `level`. The counter restarts on each return to the current level.
- A CSRRC clear takes effect at the edge that ends the instruction cycle. `out` in that cycle shows the old value.
- Reset asserted mid-count or mid-instruction clears all state immediately. It does not wait for a clock edge.

## Structure
- Add the following to `decoder_pkg`:
  - the `GpioCsrInData` and `GpioCsrInPend` address constants;
  - a shared `gpio_mask_t` typedef;
  - a helper function that extracts the operand from `csr_op`, `rs1_data` and `rs1_zimm`.
- Sub-module `gpio_in_filter`: one pin, covering the synchroniser, debounce counter and edge outputs. It is instantiated `PinNum` times through generate.
- The CSR decode and the pending register stay in the top module.

## Test plan
- Reset release with `pins=0` → `out=0` for both addresses and `irq=0`. Then raise `pins[0]` with `rise_mask=1` and `Debounce=4` → `level[0]` rises exactly 5 edges after the `sync1` capture, `pend=1`, and `irq` is high the next cycle.
- Glitch: with `Debounce=4`, hold `pins[2]` high for 3 cycles → `level` and `pend` unchanged.
- Fall masking: `rise_mask=0`, `fall_mask=0x2`; toggle `pins[1]` 0→1→0 → only the falling edge sets `pend=0x2`.
- W1C: with `pend=0x5`, CSRRCI `PendAddr` `zimm=1` → `out=0x5` in the instruction cycle, `pend=0x4` afterwards. CSRRS/CSRRW with `0xFF` → `pend` unchanged.
- Collision: a CSRRC of bit 3 on the same edge as a new event on pin 3 → `pend[3]` stays 1.
- Read-only: CSRRW `DataAddr` with `0xFFFFFFFF` → `level` unchanged. Assert `reset` low mid-debounce → all state is 0 immediately.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared CSR decode types and the GPIO input CSR definitions.
//   word / r / CsrAddrT : CSR bus operand, immediate and address types
//   csr_op_t            : CSR operation encoding (funct3 layout, bit 2 = immediate form)
//   GpioCsrInData/Pend  : addresses of the GPIO input level and pending CSRs
//   gpio_mask_t         : per-pin mask, sized for the largest supported GPIO block
package decoder_pkg;

    localparam int unsigned XLen        = 32;
    localparam int unsigned RegIdxW     = 5;
    localparam int unsigned CsrAddrW    = 12;
    localparam int unsigned GpioNum     = 8;
    localparam int unsigned GpioMaxPins = 32;

    typedef logic [XLen-1:0]        word;
    typedef logic [RegIdxW-1:0]     r;
    typedef logic [CsrAddrW-1:0]    CsrAddrT;
    typedef logic [GpioMaxPins-1:0] gpio_mask_t;

    typedef enum logic [2:0] {
        CSR_NONE = 3'b000,
        CSRRW    = 3'b001,
        CSRRS    = 3'b010,
        CSRRC    = 3'b011,
        CSRRWI   = 3'b101,
        CSRRSI   = 3'b110,
        CSRRCI   = 3'b111
    } csr_op_t;

    localparam CsrAddrT GpioCsrInData = 12'hBC4;
    localparam CsrAddrT GpioCsrInPend = 12'hBC5;

    // Operand of a CSR instruction: zero-extended zimm for the *I forms, rs1 otherwise.
    function automatic word csr_operand(input csr_op_t op, input word data, input r zimm);
        logic [2:0] w_enc;
        w_enc = op;
        return w_enc[2] ? XLen'(zimm) : data;
    endfunction

    function automatic logic csr_is_clear(input csr_op_t op);
        return (op == CSRRC) || (op == CSRRCI);
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input: two-flop synchroniser, debounce counter, filtered level and edge strobes.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_pin      : asynchronous pin
//   o_level    : filtered level (registered)
//   o_rise_c   : combinational, high in the cycle whose edge will move o_level 0->1
//   o_fall_c   : combinational, high in the cycle whose edge will move o_level 1->0
module gpio_in_filter #(
    parameter int unsigned Debounce = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned CntW    = (Debounce < 1) ? 1 : $clog2(Debounce + 1);
    localparam int unsigned CntLast = (Debounce > 1) ? Debounce - 1 : 0;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [CntW-1:0] r_cnt;
    logic            w_accept;

    // sync2 has differed from level long enough (or the filter is bypassed)
    assign w_accept = (r_sync2 != r_level) &&
                      ((Debounce <= 1) || (r_cnt == CntW'(CntLast)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign o_level  = r_level;
    assign o_rise_c = w_accept &  r_sync2;
    assign o_fall_c = w_accept & ~r_sync2;

endmodule

// File: rtl/csr_gpio_in.sv
// GPIO input CSR block: filtered pin levels (read-only CSR) and sticky edge-pending CSR.
//   clk, reset            : clock, asynchronous active-low reset
//   csr_enable/addr/op    : CSR instruction valid, address and operation
//   rs1_zimm, rs1_data    : immediate / register operand
//   pins                  : asynchronous external inputs
//   rise_mask, fall_mask  : per-pin edge event enables
//   out                   : read data of the addressed CSR (pre-operation), 0 otherwise
//   level                 : filtered pin levels
//   irq                   : OR of all pending bits
module csr_gpio_in
    import decoder_pkg::*;
#(
    parameter int unsigned PinNum   = GpioNum,
    parameter CsrAddrT     DataAddr = GpioCsrInData,
    parameter CsrAddrT     PendAddr = GpioCsrInPend,
    parameter int unsigned Debounce = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_enable,
    input  CsrAddrT           csr_addr,
    input  r                  rs1_zimm,
    input  word               rs1_data,
    input  csr_op_t           csr_op,
    input  logic [PinNum-1:0] pins,
    input  logic [PinNum-1:0] rise_mask,
    input  logic [PinNum-1:0] fall_mask,
    output word               out,
    output logic [PinNum-1:0] level,
    output logic              irq
);

    logic [PinNum-1:0] w_level;
    logic [PinNum-1:0] w_rise;
    logic [PinNum-1:0] w_fall;
    logic [PinNum-1:0] w_set;
    logic [PinNum-1:0] w_clr;
    logic [PinNum-1:0] r_pend;
    word               w_operand;
    gpio_mask_t        w_opmask;
    logic              w_pend_clr;
    logic              w_unused;

    // Per-pin synchroniser and debounce filter
    for (genvar k = 0; k < PinNum; k++) begin : g_pin
        gpio_in_filter #(
            .Debounce (Debounce)
        ) u_filter (
            .clk      (clk),
            .rst_n    (reset),
            .i_pin    (pins[k]),
            .o_level  (w_level[k]),
            .o_rise_c (w_rise[k]),
            .o_fall_c (w_fall[k])
        );
    end

    assign w_operand  = csr_operand(csr_op, rs1_data, rs1_zimm);
    assign w_opmask   = gpio_mask_t'(w_operand);
    // Operand bits above PinNum have no pending bit behind them
    assign w_unused   = ^w_opmask;
    assign w_pend_clr = csr_enable && (csr_addr == PendAddr) && csr_is_clear(csr_op);
    assign w_clr      = w_pend_clr ? w_opmask[PinNum-1:0] : '0;
    assign w_set      = (w_rise & rise_mask) | (w_fall & fall_mask);

    // Sticky pending bits; a new event wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Read mux returns the value before this instruction's effect
    always_comb begin
        out = '0;
        if (csr_enable) begin
            if (csr_addr == DataAddr) begin
                out = word'(w_level);
            end else if (csr_addr == PendAddr) begin
                out = word'(r_pend);
            end
        end
    end

    assign level = w_level;
    assign irq   = |r_pend;

endmodule

// File: tb/tb_csr_gpio_in.sv
// Directed bench for csr_gpio_in with default parameters (8 pins, Debounce=4).
module tb_csr_gpio_in;
    import decoder_pkg::*;

    localparam int unsigned PinNum = GpioNum;

    logic              clk;
    logic              rst_n;
    logic              csr_enable;
    CsrAddrT           csr_addr;
    r                  rs1_zimm;
    word               rs1_data;
    csr_op_t           csr_op;
    logic [PinNum-1:0] pins;
    logic [PinNum-1:0] rise_mask;
    logic [PinNum-1:0] fall_mask;
    word               out;
    logic [PinNum-1:0] level;
    logic              irq;

    int n_checks;
    int n_errors;
    word rd;

    csr_gpio_in u_dut (
        .clk        (clk),
        .reset      (rst_n),
        .csr_enable (csr_enable),
        .csr_addr   (csr_addr),
        .rs1_zimm   (rs1_zimm),
        .rs1_data   (rs1_data),
        .csr_op     (csr_op),
        .pins       (pins),
        .rise_mask  (rise_mask),
        .fall_mask  (fall_mask),
        .out        (out),
        .level      (level),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input word got, input word exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One CSR instruction cycle; rdata is sampled before the closing edge
    task automatic csr_do(input csr_op_t op, input CsrAddrT addr, input word data,
                          input r zimm, output word rdata);
        csr_enable = 1'b1;
        csr_op     = op;
        csr_addr   = addr;
        rs1_data   = data;
        rs1_zimm   = zimm;
        #1;
        rdata = out;
        @(posedge clk);
        #1;
        csr_enable = 1'b0;
        rs1_data   = '0;
        rs1_zimm   = '0;
    endtask

    task automatic csr_read(input CsrAddrT addr, output word rdata);
        csr_do(CSRRS, addr, 32'h0, 5'd0, rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        csr_enable = 1'b0;
        csr_addr   = '0;
        csr_op     = CSRRS;
        rs1_data   = '0;
        rs1_zimm   = '0;
        pins       = '0;
        rise_mask  = '0;
        fall_mask  = '0;
        tick(3);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Reset state through the CSR port
        csr_read(GpioCsrInData, rd);
        chk("rst_data_rd", rd, 32'h0);
        csr_read(GpioCsrInPend, rd);
        chk("rst_pend_rd", rd, 32'h0);
        chk("rst_irq_rel", 32'(irq), 32'h0);
        csr_read(12'h123, rd);
        chk("other_addr", rd, 32'h0);

        // Rising edge latency: sync1 at E1, level/pend at E6
        rise_mask = 8'h01;
        pins      = 8'h01;
        tick(5);
        chk("rise_lvl_e5", 32'(level), 32'h00);
        chk("rise_irq_e5", 32'(irq), 32'h0);
        tick(1);
        chk("rise_lvl_e6", 32'(level), 32'h01);
        chk("rise_irq_e6", 32'(irq), 32'h1);
        csr_read(GpioCsrInPend, rd);
        chk("rise_pend", rd, 32'h01);

        // Glitch of 3 cycles on pin 2 is rejected
        rise_mask = 8'hFF;
        pins      = 8'h05;
        tick(3);
        pins      = 8'h01;
        tick(10);
        chk("glitch_lvl", 32'(level), 32'h01);
        csr_read(GpioCsrInPend, rd);
        chk("glitch_pend", rd, 32'h01);

        // Fall-only mask on pin 1
        csr_do(CSRRC, GpioCsrInPend, 32'hFF, 5'd0, rd);
        rise_mask = 8'h00;
        fall_mask = 8'h02;
        csr_read(GpioCsrInPend, rd);
        chk("clr_all", rd, 32'h00);
        pins = 8'h03;
        tick(10);
        chk("fall_lvl_hi", 32'(level), 32'h03);
        csr_read(GpioCsrInPend, rd);
        chk("fall_no_rise", rd, 32'h00);
        pins = 8'h01;
        tick(10);
        chk("fall_lvl_lo", 32'(level), 32'h01);
        csr_read(GpioCsrInPend, rd);
        chk("fall_pend", rd, 32'h02);
        chk("fall_irq", 32'(irq), 32'h1);

        // Build pend=0x5: fall on pin 0, rise on pin 2
        csr_do(CSRRC, GpioCsrInPend, 32'hFF, 5'd0, rd);
        rise_mask = 8'h04;
        fall_mask = 8'h01;
        pins      = 8'h04;
        tick(10);
        chk("w1c_lvl", 32'(level), 32'h04);
        csr_do(CSRRCI, GpioCsrInPend, 32'h0, 5'd1, rd);
        chk("w1c_old", rd, 32'h05);
        csr_read(GpioCsrInPend, rd);
        chk("w1c_new", rd, 32'h04);
        csr_do(CSRRS, GpioCsrInPend, 32'hFF, 5'd0, rd);
        chk("rs_old", rd, 32'h04);
        csr_do(CSRRW, GpioCsrInPend, 32'hFF, 5'd0, rd);
        chk("rw_nomod", rd, 32'h04);
        csr_do(CSRRWI, GpioCsrInPend, 32'h0, 5'd31, rd);
        csr_read(GpioCsrInPend, rd);
        chk("rwi_nomod", rd, 32'h04);

        // Collision: clear of bit 3 on the edge that raises pend[3]
        rise_mask = 8'h08;
        fall_mask = 8'h00;
        pins      = 8'h0C;
        tick(5);
        csr_do(CSRRC, GpioCsrInPend, 32'h08, 5'd0, rd);
        chk("coll_old", rd, 32'h04);
        csr_read(GpioCsrInPend, rd);
        chk("coll_pend", rd, 32'h0C);
        chk("coll_lvl", 32'(level), 32'h0C);

        // Level CSR is read-only
        csr_do(CSRRW, GpioCsrInData, 32'hFFFF_FFFF, 5'd0, rd);
        chk("ro_old", rd, 32'h0C);
        csr_read(GpioCsrInData, rd);
        chk("ro_data", rd, 32'h0C);
        chk("ro_lvl", 32'(level), 32'h0C);

        // Reset mid-debounce clears state without a clock edge
        pins = 8'h0D;
        tick(3);
        rst_n      = 1'b0;
        csr_enable = 1'b1;
        csr_op     = CSRRS;
        csr_addr   = GpioCsrInPend;
        #1;
        chk("arst_lvl", 32'(level), 32'h00);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_pend_rd", out, 32'h00);
        csr_enable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pins high across reset rise with the full latency
        tick(5);
        chk("post_rst_e5", 32'(level), 32'h00);
        tick(1);
        chk("post_rst_e6", 32'(level), 32'h0D);
        csr_read(GpioCsrInPend, rd);
        chk("post_rst_pend", rd, 32'h08);
        chk("post_rst_irq", 32'(irq), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
